// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid data bus and
// retires fully resolved write-back data as a registered one-cycle pulse.
module mem_access_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    // Execute side: an instruction transfers on a cycle with ex_valid && ex_ready.
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_res,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_w_ena,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [2:0]        ex_funct3,
    // Memory side: request held stable until dmem_gnt; load data on dmem_rvalid.
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    // Writeback side
    output logic [XLEN-1:0]   m_data,
    output logic              m_w_ena,
    output logic [4:0]        m_w_addr,
    output logic              reg_wr,
    output logic              wb_signal,
    output logic              misalign,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q;

    logic [4:0]        rd_q;
    logic              w_ena_q;
    logic              lat_reg_wr_q;
    logic [2:0]        funct3_q;
    logic [2:0]        off_q;

    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [XLEN-1:0]   dmem_wdata_q;
    logic [7:0]        dmem_wstrb_q;

    logic [XLEN-1:0]   m_data_q;
    logic              m_w_ena_q;
    logic [4:0]        m_w_addr_q;
    logic              reg_wr_q;
    logic              misalign_q;

    logic              accept;
    logic              is_mem;
    logic              aligned;
    logic [2:0]        ex_off;
    logic [7:0]        size_mask;
    logic [7:0]        wstrb_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   load_shift;
    logic [XLEN-1:0]   load_data_d;

    assign ex_ready = (state_q == S_IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;

    // Decode of the instruction currently offered by execute.
    always_comb begin
        ex_off    = ex_alu_res[2:0];
        is_mem    = ex_mem_rd | ex_mem_wr;
        aligned   = 1'b0;
        size_mask = 8'h00;
        case (ex_funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~ex_off[0];
            3'b010, 3'b110: aligned = (ex_off[1:0] == 2'b00);
            3'b011:         aligned = (ex_off == 3'b000);
            default:        aligned = 1'b0;
        endcase
        case (ex_funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        wstrb_d = size_mask << ex_off;
        wdata_d = ex_rs2_data << {ex_off, 3'b000};
    end

    // Lane extraction of the returned doubleword with sign/zero extension.
    always_comb begin
        load_shift  = dmem_rdata >> {off_q, 3'b000};
        load_data_d = '0;
        case (funct3_q)
            3'b000:  load_data_d = {{(XLEN-8){load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_data_d = {{(XLEN-16){load_shift[15]}}, load_shift[15:0]};
            3'b010:  load_data_d = {{(XLEN-32){load_shift[31]}}, load_shift[31:0]};
            3'b011:  load_data_d = load_shift;
            3'b100:  load_data_d = {{(XLEN-8){1'b0}}, load_shift[7:0]};
            3'b101:  load_data_d = {{(XLEN-16){1'b0}}, load_shift[15:0]};
            3'b110:  load_data_d = {{(XLEN-32){1'b0}}, load_shift[31:0]};
            default: load_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_q         <= '0;
            w_ena_q      <= 1'b0;
            lat_reg_wr_q <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wstrb_q <= '0;
            m_data_q     <= '0;
            m_w_ena_q    <= 1'b0;
            m_w_addr_q   <= '0;
            reg_wr_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            // Retire registers default to a bubble every cycle.
            m_data_q   <= '0;
            m_w_ena_q  <= 1'b0;
            m_w_addr_q <= '0;
            reg_wr_q   <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            m_data_q   <= ex_alu_res;
                            m_w_ena_q  <= ex_w_ena;
                            m_w_addr_q <= ex_rd;
                            reg_wr_q   <= ex_reg_wr;
                        end else if (!aligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            rd_q         <= ex_rd;
                            w_ena_q      <= ex_w_ena;
                            lat_reg_wr_q <= ex_reg_wr;
                            funct3_q     <= ex_funct3;
                            off_q        <= ex_off;
                            dmem_req_q   <= 1'b1;
                            // A request flagged both read and write is a load.
                            dmem_we_q    <= ~ex_mem_rd;
                            dmem_addr_q  <= {ex_alu_res[ADDR_W-1:3], 3'b000};
                            dmem_wdata_q <= wdata_d;
                            dmem_wstrb_q <= ex_mem_rd ? 8'h00 : wstrb_d;
                            state_q      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= dmem_we_q ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        m_data_q   <= load_data_d;
                        m_w_ena_q  <= w_ena_q;
                        m_w_addr_q <= rd_q;
                        reg_wr_q   <= lat_reg_wr_q;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wstrb = dmem_wstrb_q;

    assign m_data     = m_data_q;
    assign m_w_ena    = m_w_ena_q;
    assign m_w_addr   = m_w_addr_q;
    assign reg_wr     = reg_wr_q;
    assign misalign   = misalign_q;
    // Write-back data is already resolved here, so MemtoReg never selects memory.
    assign wb_signal  = 1'b0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized traffic checked
// against a size/offset arithmetic model of the memory-access rules.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_alu_res;
    logic [63:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_w_ena;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic [63:0] m_data;
    logic        m_w_ena;
    logic [4:0]  m_w_addr;
    logic        reg_wr;
    logic        wb_signal;
    logic        misalign;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        w_ena;
        logic [4:0]  addr;
        logic        reg_wr;
        logic        mis;
    } ret_t;

    ret_t exp_q[$];

    mem_access_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_res(ex_alu_res), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_wr(ex_reg_wr), .ex_w_ena(ex_w_ena),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .m_data(m_data), .m_w_ena(m_w_ena), .m_w_addr(m_w_addr),
        .reg_wr(reg_wr), .wb_signal(wb_signal), .misalign(misalign),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: access size, legality, lanes and extension
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input logic [2:0] f3, input logic [63:0] alu);
        int off;
        off = int'(alu[2:0]);
        if (f3 == 3'b111) return 1'b0;
        return (off % size_of(f3)) == 0;
    endfunction

    function automatic logic [63:0] load_val(input logic [2:0] f3, input int off,
                                             input logic [63:0] rdata);
        int nb;
        logic [63:0] v;
        logic [63:0] lo_mask;
        nb = size_of(f3);
        v = rdata >> (8 * off);
        if (nb < 8) begin
            lo_mask = (64'd1 << (8 * nb)) - 64'd1;
            v = v & lo_mask;
            if (!f3[2] && v[8 * nb - 1]) v = v | ~lo_mask;
        end
        return v;
    endfunction

    function automatic logic [7:0] store_strb(input logic [2:0] f3, input int off);
        logic [7:0] m;
        m = 8'((1 << size_of(f3)) - 1);
        return m << off;
    endfunction

    // Drivers
    task automatic clear_inputs();
        ex_valid = 1'b0; ex_alu_res = '0; ex_rs2_data = '0; ex_rd = '0;
        ex_reg_wr = 1'b0; ex_w_ena = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
        ex_funct3 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic drive_op(input logic [63:0] alu, input logic [63:0] rs2,
                            input logic [4:0] rd, input logic rw, input logic wen,
                            input logic mrd, input logic mwr, input logic [2:0] f3);
        ex_valid = 1'b1; ex_alu_res = alu; ex_rs2_data = rs2; ex_rd = rd;
        ex_reg_wr = rw; ex_w_ena = wen; ex_mem_rd = mrd; ex_mem_wr = mwr;
        ex_funct3 = f3;
    endtask

    // Scenarios
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_req, ex_ready, m_w_ena, reg_wr, misalign, wb_signal} !== 6'b0 || m_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b ready=%b w_ena=%b reg_wr=%b mis=%b data=%h required all 0",
                     dmem_req, ex_ready, m_w_ena, reg_wr, misalign, m_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b required 1", ex_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        drive_op(64'h1234, 64'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (m_data !== 64'h1234 || m_w_addr !== 5'd5 || reg_wr !== 1'b1 || m_w_ena !== 1'b1
            || wb_signal !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL alu_retire: data=%h addr=%0d reg_wr=%b w_ena=%b wb=%b mis=%b required 1234/5/1/1/0/0",
                     m_data, m_w_addr, reg_wr, m_w_ena, wb_signal, misalign);
        end
        @(negedge clk);
        checks++;
        if (m_data !== 64'd0 || m_w_addr !== 5'd0 || reg_wr !== 1'b0 || m_w_ena !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL alu_bubble: data=%h addr=%0d reg_wr=%b w_ena=%b required all 0",
                     m_data, m_w_addr, reg_wr, m_w_ena);
        end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [63:0] exp_data);
        drive_op(64'h1003, 64'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, f3);
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000 || dmem_we !== 1'b0 || ex_ready !== 1'b0) begin
            failures++;
            $display("FAIL lb_request: req=%b addr=%h we=%b ready=%b required 1/1000/0/0",
                     dmem_req, dmem_addr, dmem_we, ex_ready);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || reg_wr !== 1'b0) begin
            failures++; $display("FAIL lb_wait: req=%b reg_wr=%b required 0/0", dmem_req, reg_wr);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'h00000000_80000000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++;
        if (m_data !== exp_data || m_w_addr !== 5'd9 || reg_wr !== 1'b1 || m_w_ena !== 1'b1 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL lb_retire f3=%0d: data=%h addr=%0d reg_wr=%b w_ena=%b ready=%b required data=%h addr=9 1/1/1",
                     f3, m_data, m_w_addr, reg_wr, m_w_ena, ex_ready, exp_data);
        end
    endtask

    task automatic test_store_half();
        drive_op(64'h2006, 64'hBEEF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h2000
                || dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'hBEEF_0000_0000_0000) begin
                failures++;
                $display("FAIL sh_hold cycle %0d: req=%b we=%b addr=%h strb=%h wdata=%h required 1/1/2000/c0/beef000000000000",
                         c, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
            end
            dmem_gnt = (c == 3);
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || reg_wr !== 1'b0 || m_w_ena !== 1'b0 || misalign !== 1'b0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL sh_retire: req=%b reg_wr=%b w_ena=%b mis=%b ready=%b required 0/0/0/0/1",
                     dmem_req, reg_wr, m_w_ena, misalign, ex_ready);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] alus[2];
        logic [2:0]  f3s[2];
        alus[0] = 64'h3002; f3s[0] = 3'b010;
        alus[1] = 64'h4000; f3s[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            drive_op(alus[i], 64'h55, 5'd3, 1'b1, 1'b1, (i == 0), (i == 1), f3s[i]);
            @(negedge clk);
            ex_valid = 1'b0;
            checks++;
            if (misalign !== 1'b1 || reg_wr !== 1'b0 || m_w_ena !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
                failures++;
                $display("FAIL misalign_%0d: mis=%b reg_wr=%b w_ena=%b req=%b ready=%b required 1/0/0/0/1",
                         i, misalign, reg_wr, m_w_ena, dmem_req, ex_ready);
            end
            @(negedge clk);
            checks++;
            if (misalign !== 1'b0 || dmem_req !== 1'b0) begin
                failures++; $display("FAIL misalign_pulse_%0d: mis=%b req=%b required 0/0", i, misalign, dmem_req);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        // Reset while a store request is pending: request must drop at once.
        drive_op(64'h6008, 64'h1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b0) begin
            failures++; $display("FAIL rst_req_drop: req=%b ready=%b required 0/0", dmem_req, ex_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset while waiting for load data; a late rvalid must be ignored.
        drive_op(64'h5000, 64'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011);
        @(negedge clk);
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || m_w_ena !== 1'b0 || reg_wr !== 1'b0 || m_data !== 64'd0) begin
                failures++;
                $display("FAIL rst_wait_%0d: req=%b ready=%b w_ena=%b reg_wr=%b data=%h required 0/1/0/0/0",
                         c, dmem_req, ex_ready, m_w_ena, reg_wr, m_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals[4];
        for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            drive_op(vals[i], 64'd0, 5'(i + 10), 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
            @(negedge clk);
            checks++;
            if (m_data !== vals[i] || m_w_addr !== 5'(i + 10) || reg_wr !== 1'b1 || ex_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d: data=%h addr=%0d reg_wr=%b ready=%b required %h/%0d/1/1",
                         i, m_data, m_w_addr, reg_wr, ex_ready, vals[i], i + 10);
            end
        end
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_wr !== 1'b0 || m_w_ena !== 1'b0 || m_data !== 64'd0) begin
            failures++; $display("FAIL b2b_bubble: reg_wr=%b w_ena=%b data=%h required 0/0/0", reg_wr, m_w_ena, m_data);
        end
    endtask

    task automatic test_random();
        logic [63:0] alu, rs2, rdata;
        logic [4:0]  rd;
        logic        rw, wen, mrd, mwr, ok;
        logic [2:0]  f3;
        int          kind, off, d;
        ret_t        e;
        for (int t = 0; t < 120; t++) begin
            alu = {$urandom, $urandom};
            rs2 = {$urandom, $urandom};
            rd  = 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
            mrd = (kind == 1) || (kind == 3);
            mwr = (kind == 2) || (kind == 3);
            f3  = 3'($urandom_range(0, 7));
            if (mwr && !mrd && f3[2] && f3 != 3'b111) f3[2] = 1'b0;
            if ($urandom_range(0, 1) == 1) alu[2:0] = 3'b000;
            off = int'(alu[2:0]);
            ok  = legal(f3, alu);
            checks++;
            if (ex_ready !== 1'b1) begin
                failures++; $display("FAIL rnd_ready t=%0d: got %b required 1", t, ex_ready);
            end
            drive_op(alu, rs2, rd, rw, wen, mrd, mwr, f3);
            @(negedge clk);
            ex_valid = 1'b0;
            if (!(mrd || mwr)) begin
                exp_q.push_back('{alu, wen, rd, rw, 1'b0});
            end else if (!ok) begin
                exp_q.push_back('{64'd0, 1'b0, 5'd0, 1'b0, 1'b1});
            end else begin
                d = $urandom_range(0, 3);
                for (int c = 0; c <= d; c++) begin
                    checks++;
                    if (dmem_req !== 1'b1 || dmem_addr !== {alu[63:3], 3'b000} || dmem_we !== (mwr && !mrd)) begin
                        failures++;
                        $display("FAIL rnd_bus t=%0d: req=%b addr=%h we=%b required 1/%h/%b",
                                 t, dmem_req, dmem_addr, dmem_we, {alu[63:3], 3'b000}, mwr && !mrd);
                    end
                    if (mwr && !mrd) begin
                        checks++;
                        if (dmem_wstrb !== store_strb(f3, off) || dmem_wdata !== (rs2 << (8 * off))) begin
                            failures++;
                            $display("FAIL rnd_store t=%0d: strb=%h wdata=%h required %h/%h",
                                     t, dmem_wstrb, dmem_wdata, store_strb(f3, off), rs2 << (8 * off));
                        end
                    end
                    dmem_gnt = (c == d);
                    dmem_rvalid = (c < d) ? 1'($urandom_range(0, 1)) : 1'b0;
                    dmem_rdata = {$urandom, $urandom};
                    @(negedge clk);
                end
                dmem_gnt = 1'b0;
                dmem_rvalid = 1'b0;
                if (mrd) begin
                    rdata = {$urandom, $urandom};
                    d = $urandom_range(0, 3);
                    for (int c = 0; c <= d; c++) begin
                        checks++;
                        if (dmem_req !== 1'b0 || m_w_ena !== 1'b0 || reg_wr !== 1'b0) begin
                            failures++;
                            $display("FAIL rnd_wait t=%0d: req=%b w_ena=%b reg_wr=%b required 0/0/0",
                                     t, dmem_req, m_w_ena, reg_wr);
                        end
                        dmem_rvalid = (c == d);
                        dmem_rdata = (c == d) ? rdata : {$urandom, $urandom};
                        @(negedge clk);
                    end
                    dmem_rvalid = 1'b0;
                    exp_q.push_back('{load_val(f3, off, rdata), wen, rd, rw, 1'b0});
                end else begin
                    exp_q.push_back('{64'd0, 1'b0, 5'd0, 1'b0, 1'b0});
                end
            end
            e = exp_q.pop_front();
            checks++;
            if ({m_data, m_w_ena, m_w_addr, reg_wr, misalign} !== e || wb_signal !== 1'b0) begin
                failures++;
                $display("FAIL rnd_retire t=%0d f3=%0d rd/wr=%b%b: data=%h w_ena=%b addr=%0d reg_wr=%b mis=%b required data=%h w_ena=%b addr=%0d reg_wr=%b mis=%b",
                         t, f3, mrd, mwr, m_data, m_w_ena, m_w_addr, reg_wr, misalign,
                         e.data, e.w_ena, e.addr, e.reg_wr, e.mis);
            end
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                checks++;
                if (m_data !== 64'd0 || m_w_ena !== 1'b0 || reg_wr !== 1'b0 || misalign !== 1'b0 || m_w_addr !== 5'd0) begin
                    failures++;
                    $display("FAIL rnd_bubble t=%0d: data=%h w_ena=%b reg_wr=%b mis=%b required all 0",
                             t, m_data, m_w_ena, reg_wr, misalign);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load_byte(3'b100, 64'h0000_0000_0000_0080);
        test_store_half();
        test_misalign();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
